// File: rtl/io_cycle_master_if.sv
// Handshake and bus signals of the Z80-style I/O cycle initiator.
// The master modport is the initiator's view. The slave modport is the
// requester/responder view used by whoever drives the block.
interface io_cycle_master_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic        bus_ioreq;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_d_in;
  logic        bus_wait;

  modport master (
    input  req, we, addr, wdata, bus_d_in, bus_wait,
    output busy, done, rdata, bus_a, bus_d_out, bus_d_oe,
           bus_ioreq, bus_rd, bus_wr
  );

  modport slave (
    output req, we, addr, wdata, bus_d_in, bus_wait,
    input  busy, done, rdata, bus_a, bus_d_out, bus_d_oe,
           bus_ioreq, bus_rd, bus_wr
  );
endinterface

// File: rtl/io_cycle_master.sv
// Z80-style I/O cycle initiator: IDLE -> T1 -> T2 -> TW (repeats while
// bus_wait) -> T3 -> IDLE. Each T-state spans T_CLKS clk28 periods.
// Every output is a register. The comb process computes next values and
// the sequential process loads them.
module io_cycle_master #(
  parameter int T_CLKS = 8
) (
  input  logic             clk28,
  input  logic             rst,
  io_cycle_master_if.master bus_if
);
  localparam int CW = $clog2(T_CLKS);
  localparam logic [CW-1:0] LAST = CW'(T_CLKS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic           r_we, w_we_nx;
  logic           r_busy, w_busy_nx;
  logic           r_done, w_done_nx;
  logic [7:0]     r_rdata, w_rdata_nx;
  logic [15:0]    r_bus_a, w_a_nx;
  logic [7:0]     r_bus_d_out, w_dout_nx;
  logic           r_bus_d_oe, w_doe_nx;
  logic           r_bus_ioreq, w_ioreq_nx;
  logic           r_bus_rd, w_rd_nx;
  logic           r_bus_wr, w_wr_nx;
  logic           w_last;

  // The final clock of the current T-state.
  assign w_last = (r_cnt == LAST);

  // State register and registered outputs. Reset aborts any cycle at once.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_bus_a     <= '0;
      r_bus_d_out <= '0;
      r_bus_d_oe  <= 1'b0;
      r_bus_ioreq <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_bus_wr    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_we        <= w_we_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_rdata     <= w_rdata_nx;
      r_bus_a     <= w_a_nx;
      r_bus_d_out <= w_dout_nx;
      r_bus_d_oe  <= w_doe_nx;
      r_bus_ioreq <= w_ioreq_nx;
      r_bus_rd    <= w_rd_nx;
      r_bus_wr    <= w_wr_nx;
    end
  end

  // Next state, T-state counter and next output values. Everything holds by
  // default. done is a single-clock pulse, so it defaults low.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_we_nx    = r_we;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_rdata_nx = r_rdata;
    w_a_nx     = r_bus_a;
    w_dout_nx  = r_bus_d_out;
    w_doe_nx   = r_bus_d_oe;
    w_ioreq_nx = r_bus_ioreq;
    w_rd_nx    = r_bus_rd;
    w_wr_nx    = r_bus_wr;
    unique case (r_state)
      ST_IDLE: begin
        // req is only looked at here, so a request during a cycle is dropped.
        if (bus_if.req) begin
          w_state_nx = ST_T1;
          w_cnt_nx   = '0;
          w_we_nx    = bus_if.we;
          w_busy_nx  = 1'b1;
          w_a_nx     = bus_if.addr;
          if (bus_if.we) begin
            w_doe_nx  = 1'b1;
            w_dout_nx = bus_if.wdata;
          end
        end
      end
      ST_T1: begin
        if (w_last) begin
          w_state_nx = ST_T2;
          w_cnt_nx   = '0;
          w_ioreq_nx = 1'b1;
          w_rd_nx    = ~r_we;
          w_wr_nx    = r_we;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_T2: begin
        if (w_last) begin
          w_state_nx = ST_TW;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_TW: begin
        // bus_wait matters only on the edge that closes a TW.
        if (w_last) begin
          w_cnt_nx = '0;
          if (!bus_if.bus_wait) w_state_nx = ST_T3;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_T3: begin
        if (w_last) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_doe_nx   = 1'b0;
          w_ioreq_nx = 1'b0;
          w_rd_nx    = 1'b0;
          w_wr_nx    = 1'b0;
          if (!r_we) w_rdata_nx = bus_if.bus_d_in;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign bus_if.busy      = r_busy;
  assign bus_if.done      = r_done;
  assign bus_if.rdata     = r_rdata;
  assign bus_if.bus_a     = r_bus_a;
  assign bus_if.bus_d_out = r_bus_d_out;
  assign bus_if.bus_d_oe  = r_bus_d_oe;
  assign bus_if.bus_ioreq = r_bus_ioreq;
  assign bus_if.bus_rd    = r_bus_rd;
  assign bus_if.bus_wr    = r_bus_wr;
endmodule

// File: tb/tb_io_cycle_master.sv
// Bench for io_cycle_master. Expected values come from a cycle-level model:
// a cycle lasts T*(4+waits) clocks, and the strobes are high from clock T
// until the end of the cycle.
module tb_io_cycle_master;
  localparam int T    = 8;
  localparam int MAXK = 80;

  logic clk28 = 1'b0;
  logic rst   = 1'b0;
  always #5 clk28 = ~clk28;

  io_cycle_master_if ifc();
  io_cycle_master #(.T_CLKS(T)) dut (.clk28(clk28), .rst(rst), .bus_if(ifc));

  typedef struct packed {
    logic busy, done, ioreq, rd, wr, doe;
    logic [15:0] a;
    logic [7:0]  dout, rdata;
  } obs_t;

  obs_t        tr [0:MAXK];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  m_rdata = '0;
  logic [7:0]  m_dout  = '0;

  function automatic obs_t sample();
    obs_t o;
    o.busy = ifc.busy;      o.done = ifc.done;   o.ioreq = ifc.bus_ioreq;
    o.rd   = ifc.bus_rd;    o.wr   = ifc.bus_wr; o.doe   = ifc.bus_d_oe;
    o.a    = ifc.bus_a;     o.dout = ifc.bus_d_out; o.rdata = ifc.rdata;
    return o;
  endfunction

  // Issue one request and record the bus after each edge until done.
  // bus_wait is random except on the edges that close a TW, and bus_d_in is
  // random except on the done edge. pulse_at re-asserts req for one edge.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input int nwait, input int pulse_at,
                         output int dk);
    int len;
    len = T * (4 + nwait);
    @(negedge clk28);
    ifc.req = 1'b1; ifc.we = w; ifc.addr = a; ifc.wdata = wd;
    ifc.bus_wait = 1'($urandom); ifc.bus_d_in = 8'($urandom);
    @(posedge clk28); #1;
    tr[0] = sample();
    dk = -1;
    for (int m = 1; m <= MAXK && dk < 0; m++) begin
      ifc.req   = (m == pulse_at);
      ifc.we    = 1'($urandom); ifc.addr = 16'($urandom); ifc.wdata = 8'($urandom);
      ifc.bus_d_in = (m == len) ? din : 8'($urandom);
      if (m >= 3*T && (m % T) == 0 && m <= 3*T + nwait*T) ifc.bus_wait = (m < 3*T + nwait*T);
      else ifc.bus_wait = 1'($urandom);
      @(posedge clk28); #1;
      tr[m] = sample();
      if (tr[m].done) dk = m;
    end
    ifc.req = 1'b0; ifc.bus_wait = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    ifc.req = 0; ifc.we = 0; ifc.addr = '0; ifc.wdata = '0; ifc.bus_d_in = '0; ifc.bus_wait = 0;
    #2 rst = 1'b1;
    #1 o = sample();
    n_cmp++;
    if (o !== obs_t'(0)) begin n_bad++; $display("FAIL reset_async got %h exp 0", o); end
    repeat (2) @(posedge clk28);
    @(negedge clk28) rst = 1'b0;
    @(posedge clk28); #1 o = sample();
    n_cmp++;
    if (o !== obs_t'(0)) begin n_bad++; $display("FAIL reset_idle got %h exp 0", o); end
    m_rdata = '0; m_dout = '0;
  endtask

  task automatic test_write();
    int dk;
    run_txn(1'b1, 16'h00FE, 8'h15, 8'hA5, 0, -1, dk);
    n_cmp++;
    if (dk !== 4*T) begin n_bad++; $display("FAIL wr_done_clk got %0d exp %0d", dk, 4*T); end
    for (int k = 0; k < 4*T; k++) begin
      n_cmp++;
      if ({tr[k].doe, tr[k].ioreq, tr[k].wr, tr[k].rd, tr[k].a, tr[k].dout} !==
          {1'b1, k >= T, k >= T, 1'b0, 16'h00FE, 8'h15}) begin
        n_bad++; $display("FAIL wr_clk%0d got %h exp doe=1 strobe=%0d", k, tr[k], k >= T);
      end
    end
    n_cmp++;
    if ({tr[4*T].done, tr[4*T].busy, tr[4*T].doe, tr[4*T].ioreq, tr[4*T].wr, tr[4*T].rdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_rdata}) begin
      n_bad++; $display("FAIL wr_end got %h exp rdata %h", tr[4*T], m_rdata);
    end
    m_dout = 8'h15;
  endtask

  task automatic test_read();
    int dk;
    run_txn(1'b0, 16'h7FFE, 8'h33, 8'hBF, 0, -1, dk);
    n_cmp++;
    if (dk !== 4*T) begin n_bad++; $display("FAIL rd_done_clk got %0d exp %0d", dk, 4*T); end
    for (int k = 0; k < 4*T; k++) begin
      n_cmp++;
      if ({tr[k].doe, tr[k].ioreq, tr[k].rd, tr[k].wr, tr[k].a, tr[k].dout} !==
          {1'b0, k >= T, k >= T, 1'b0, 16'h7FFE, m_dout}) begin
        n_bad++; $display("FAIL rd_clk%0d got %h exp rd=%0d", k, tr[k], k >= T);
      end
    end
    n_cmp++;
    if ({tr[4*T].done, tr[4*T].rd, tr[4*T].rdata} !== {1'b1, 1'b0, 8'hBF}) begin
      n_bad++; $display("FAIL rd_end got %h exp rdata bf", tr[4*T]);
    end
    m_rdata = 8'hBF;
  endtask

  task automatic test_wait();
    int dk;
    logic [7:0] din;
    din = 8'($urandom);
    run_txn(1'b0, 16'h1234, 8'h00, din, 1, -1, dk);
    n_cmp++;
    if (dk !== 5*T) begin n_bad++; $display("FAIL wait_done_clk got %0d exp %0d", dk, 5*T); end
    for (int k = 0; k < 5*T; k++) begin
      n_cmp++;
      if ({tr[k].busy, tr[k].ioreq, tr[k].rd} !== {1'b1, k >= T, k >= T}) begin
        n_bad++; $display("FAIL wait_clk%0d got %h exp rd=%0d", k, tr[k], k >= T);
      end
    end
    n_cmp++;
    if (tr[5*T].rdata !== din) begin n_bad++; $display("FAIL wait_rdata got %h exp %h", tr[5*T].rdata, din); end
    m_rdata = din;
  endtask

  task automatic test_overlap();
    int dk;
    logic [7:0] wd;
    obs_t o;
    wd = 8'($urandom);
    run_txn(1'b1, 16'hBEEF, wd, 8'h00, 0, 5, dk);
    n_cmp++;
    if (dk !== 4*T) begin n_bad++; $display("FAIL ovl_done_clk got %0d exp %0d", dk, 4*T); end
    m_dout = wd;
    for (int k = 0; k < 2*T; k++) begin
      @(posedge clk28); #1 o = sample();
      n_cmp++;
      if ({o.busy, o.done, o.rdata, o.dout} !== {1'b0, 1'b0, m_rdata, m_dout}) begin
        n_bad++; $display("FAIL ovl_after%0d got %h exp idle", k, o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, a2, d2;
    logic pb;
    obs_t o;
    d1 = -1; a2 = -1; d2 = -1;
    @(negedge clk28);
    ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 16'h4321; ifc.bus_wait = 1'b0; ifc.bus_d_in = 8'h5A;
    @(posedge clk28); #1 pb = ifc.busy;
    for (int m = 1; m <= 3*MAXK && d2 < 0; m++) begin
      @(posedge clk28); #1 o = sample();
      if (o.done && d1 < 0) d1 = m;
      else if (o.done) d2 = m;
      if (o.busy && !pb && a2 < 0) a2 = m;
      pb = o.busy;
    end
    ifc.req = 1'b0;
    n_cmp++;
    if (d1 !== 4*T) begin n_bad++; $display("FAIL b2b_done1 got %0d exp %0d", d1, 4*T); end
    n_cmp++;
    if (a2 !== 4*T + 1) begin n_bad++; $display("FAIL b2b_accept2 got %0d exp %0d", a2, 4*T + 1); end
    n_cmp++;
    if (d2 !== 8*T + 1) begin n_bad++; $display("FAIL b2b_done2 got %0d exp %0d", d2, 8*T + 1); end
    n_cmp++;
    if (ifc.rdata !== 8'h5A) begin n_bad++; $display("FAIL b2b_rdata got %h exp 5a", ifc.rdata); end
    m_rdata = 8'h5A;
    @(posedge clk28); #1;
  endtask

  task automatic test_reset_mid();
    int dk;
    obs_t o;
    logic [7:0] din;
    @(negedge clk28);
    ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 16'hAAAA; ifc.wdata = 8'h77;
    @(posedge clk28); #1 ifc.req = 1'b0;
    repeat (12) @(posedge clk28);
    #1 o = sample();
    n_cmp++;
    if ({o.ioreq, o.wr, o.doe, o.busy} !== 4'b1111) begin n_bad++; $display("FAIL rst_pre got %h exp strobes high", o); end
    #2 rst = 1'b1;
    #1 o = sample();
    n_cmp++;
    if (o !== obs_t'(0)) begin n_bad++; $display("FAIL rst_mid got %h exp 0", o); end
    m_rdata = '0; m_dout = '0;
    repeat (2) @(posedge clk28);
    @(negedge clk28) rst = 1'b0;
    for (int k = 0; k < 3*T; k++) begin
      @(posedge clk28); #1 o = sample();
      n_cmp++;
      if ({o.busy, o.done} !== 2'b00) begin n_bad++; $display("FAIL rst_nodone%0d got %h exp idle", k, o); end
    end
    din = 8'($urandom);
    run_txn(1'b0, 16'h0102, 8'h00, din, 0, -1, dk);
    n_cmp++;
    if ({dk == 4*T, tr[4*T].rdata} !== {1'b1, din}) begin
      n_bad++; $display("FAIL rst_read got clk %0d rdata %h exp clk %0d rdata %h", dk, tr[4*T].rdata, 4*T, din);
    end
    m_rdata = din;
  endtask

  task automatic test_random();
    int dk, len, nw;
    logic w;
    logic [15:0] a;
    logic [7:0] wd, din;
    obs_t e;
    for (int t = 0; t < 20; t++) begin
      w = 1'($urandom); a = 16'($urandom); wd = 8'($urandom); din = 8'($urandom);
      nw = $urandom_range(0, 3);
      len = T * (4 + nw);
      run_txn(w, a, wd, din, nw, -1, dk);
      n_cmp++;
      if (dk !== len) begin n_bad++; $display("FAIL rand%0d_len got %0d exp %0d", t, dk, len); end
      for (int k = 0; k <= len; k++) begin
        e.busy  = (k < len);
        e.done  = (k == len);
        e.ioreq = (k >= T) && (k < len);
        e.rd    = e.ioreq && !w;
        e.wr    = e.ioreq && w;
        e.doe   = w && (k < len);
        e.a     = a;
        e.dout  = w ? wd : m_dout;
        e.rdata = (k == len && !w) ? din : m_rdata;
        n_cmp++;
        if (tr[k] !== e) begin n_bad++; $display("FAIL rand%0d_clk%0d got %h exp %h", t, k, tr[k], e); end
      end
      if (w) m_dout = wd; else m_rdata = din;
      repeat ($urandom_range(0, 2)) @(posedge clk28);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait();
    test_overlap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
